// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller.
// Loads are staged in a pending register. They reach the display only at a
// frame boundary, so a frame never mixes old and new digits.
// Optional feature: define SEG_LZB_EN to blank leading zeros.
module seg_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     en_mask,
    input  logic                  load,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            segment_data,
    output logic                  frame_done
);

    localparam int              IW       = $clog2(DIGITS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ACTIVE_LOW != 0}};
    localparam logic [7:0]      SEG_OFF  = {8{ACTIVE_LOW != 0}};

    logic [DIV_W-1:0]     pre;
    logic [IW-1:0]        idx, idx_nxt;
    logic                 tick, wrap;
    logic [4*DIGITS-1:0]  pend_data, act_data, act_data_nxt;
    logic [DIGITS-1:0]    pend_dp, act_dp, act_dp_nxt;
    logic [DIGITS-1:0]    pend_en, act_en, act_en_nxt;
    logic [3:0]           nib;
    logic                 dp_bit, blank;
    logic [DIGITS-1:0]    sel_onehot;

    // Hex nibble to active-high segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Slot tick, frame wrap, next index and next active frame contents
    always_comb begin
        tick         = &pre;
        wrap         = tick && (idx == LAST_IDX);
        idx_nxt      = idx;
        act_data_nxt = act_data;
        act_dp_nxt   = act_dp;
        act_en_nxt   = act_en;
        if (tick)
            idx_nxt = wrap ? '0 : idx + IW'(1);
        if (wrap) begin
            // A load landing on the wrap cycle bypasses pending
            act_data_nxt = load ? data    : pend_data;
            act_dp_nxt   = load ? dp      : pend_dp;
            act_en_nxt   = load ? en_mask : pend_en;
        end
    end

`ifdef SEG_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              hi_zero;

    // Leading-zero map: a zero digit with no significant enabled digit above it
    always_comb begin
        lz      = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz[i] = hi_zero && (act_data_nxt[4*i +: 4] == 4'h0);
            if (act_en_nxt[i] && (act_data_nxt[4*i +: 4] != 4'h0))
                hi_zero = 1'b0;
        end
    end
`endif

    // Select the digit that will be shown after this edge
    always_comb begin
        nib        = act_data_nxt[{idx_nxt, 2'b00} +: 4];
        dp_bit     = act_dp_nxt[idx_nxt];
        sel_onehot = DIGITS'(1) << idx_nxt;
`ifdef SEG_LZB_EN
        blank      = !act_en_nxt[idx_nxt] || lz[idx_nxt];
`else
        blank      = !act_en_nxt[idx_nxt];
`endif
    end

    // Prescaler, digit index, frame pulse and the pending/active registers.
    // The enable mask resets to all-on, so after reset every digit shows 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_en    <= '1;
            act_data   <= '0;
            act_dp     <= '0;
            act_en     <= '1;
        end else begin
            pre        <= pre + DIV_W'(1);
            idx        <= idx_nxt;
            frame_done <= wrap;
            act_data   <= act_data_nxt;
            act_dp     <= act_dp_nxt;
            act_en     <= act_en_nxt;
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp;
                pend_en   <= en_mask;
            end
        end
    end

    // Registered anode and segment drive, polarity applied last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            AN           <= AN_OFF;
            segment_data <= SEG_OFF;
        end else if (blank) begin
            AN           <= AN_OFF;
            segment_data <= SEG_OFF;
        end else begin
            AN           <= sel_onehot ^ AN_OFF;
            segment_data <= {dp_bit, hex7(nib)} ^ SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIGITS=4, DIV_W=2, ACTIVE_LOW=1).
// The edge count k after reset release fixes the slot: digit = (k/4)%4.
// A frame completes on every 16th edge.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  en_mask = 4'hF;
    logic [3:0]  AN;
    logic [7:0]  segment_data;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int k = 0;

`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // Frame the display is expected to show, set by hand at each frame switch
    logic [15:0] cur_data;
    logic [3:0]  cur_dp;
    logic [3:0]  cur_blank;

    // Active-high glyphs {g..a} for 0..F
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_ctrl #(.DIGITS(4), .DIV_W(2), .ACTIVE_LOW(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .data         (data),
        .dp           (dp),
        .en_mask      (en_mask),
        .load         (load),
        .AN           (AN),
        .segment_data (segment_data),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic check_slot();
        int d;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic [3:0] nb;
        d  = (k / 4) % 4;
        nb = cur_data[d*4 +: 4];
        if (cur_blank[d]) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            exp_an  = ~(4'b0001 << d);
            exp_seg = ~{cur_dp[d], glyph[nb]};
        end
        chk("an", AN, exp_an);
        chk("seg", segment_data, exp_seg);
        chk("frame_done", frame_done, (k % 16) == 0);
    endtask

    task automatic run_to(input int kend);
        while (k < kend) begin
            step();
            check_slot();
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        data = d; dp = p; en_mask = e; load = 1'b1;
        step();
        check_slot();
        load = 1'b0;
    endtask

    initial begin
        // Reset and release; outputs must be off while held
        #1 rst = 1'b0;
        #11;
        chk("rst_an", AN, 4'hF);
        chk("rst_seg", segment_data, 8'hFF);
        chk("rst_fd", frame_done, 1'b0);
        #1 rst = 1'b1;
        k = 0;

        // Free scan after reset: zeros on every digit
        cur_data = 16'h0000; cur_dp = 4'h0; cur_blank = LZB ? 4'b1110 : 4'b0000;
        run_to(32);

        // Two mid-frame loads: only the last shows, and only from the next wrap
        run_to(37);
        pulse_load(16'hFFFF, 4'hF, 4'hF);
        run_to(41);
        pulse_load(16'h12AF, 4'b0100, 4'hF);
        run_to(47);
        cur_data = 16'h12AF; cur_dp = 4'b0100; cur_blank = 4'b0000;
        run_to(63);

        // Load on the wrap cycle takes effect in the very next slot
        cur_data = 16'h0008; cur_dp = 4'h0; cur_blank = LZB ? 4'b1110 : 4'b0000;
        pulse_load(16'h0008, 4'h0, 4'hF);
        chk("bypass_d0", segment_data, 8'h80);
        run_to(70);

        // Digit 2 disabled
        pulse_load(16'h4321, 4'h0, 4'b1011);
        run_to(79);
        cur_data = 16'h4321; cur_dp = 4'h0; cur_blank = 4'b0100;
        run_to(100);

        // Leading-zero candidate 0050
        pulse_load(16'h0050, 4'h0, 4'hF);
        run_to(111);
        cur_data = 16'h0050; cur_dp = 4'h0; cur_blank = LZB ? 4'b1100 : 4'b0000;
        run_to(129);

        // Pending load, then async reset mid-slot: pending must be discarded
        pulse_load(16'hABCD, 4'hF, 4'hF);
        #2 rst = 1'b0;
        #1;
        chk("arst_an", AN, 4'hF);
        chk("arst_seg", segment_data, 8'hFF);
        chk("arst_fd", frame_done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("hold_an", AN, 4'hF);
        chk("hold_seg", segment_data, 8'hFF);
        #2 rst = 1'b1;
        k = 0;
        cur_data = 16'h0000; cur_dp = 4'h0; cur_blank = LZB ? 4'b1110 : 4'b0000;
        run_to(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
